// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data-memory port between the CPU and a debug/host port.
// Optional perf counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [15:0]       perf_cpu_cnt,
    output logic [15:0]       perf_dbg_cnt,
    output logic [15:0]       perf_conflict_cnt,
    output logic [15:0]       perf_starve_cnt
`endif
);

    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [0:0] {ST_ARB, ST_DBG_LOCKED} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cpu_rvalid_q, dbg_rvalid_q;
    logic              guard_win;

    // Grant decode: a held lock overrides CPU priority, otherwise CPU wins unless debug is starved.
    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        guard_win = 1'b0;
        state_d   = state_q;
        if (resetn) begin
            if (state_q == ST_DBG_LOCKED && dbg_req && dbg_lock) begin
                dbg_gnt = 1'b1;
            end else begin
                if (cpu_req && dbg_req) begin
                    if (starve_q == STARVE_LIM) begin
                        dbg_gnt   = 1'b1;
                        guard_win = 1'b1;
                    end else begin
                        cpu_gnt = 1'b1;
                    end
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (dbg_req) begin
                    dbg_gnt = 1'b1;
                end
                state_d = (dbg_gnt && dbg_lock) ? ST_DBG_LOCKED : ST_ARB;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!dbg_req || dbg_gnt) begin
            starve_d = '0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Idle cycles replay the last granted address/data so the memory pins stay quiet.
    always_comb begin
        mem_we    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_ARB;
            starve_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            addr_q       <= mem_addr;
            wdata_q      <= mem_wdata;
            cpu_rvalid_q <= cpu_gnt & ~cpu_we;
            dbg_rvalid_q <= dbg_gnt & ~dbg_we;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] pcpu_q, pdbg_q, pconf_q, pstarve_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pcpu_q    <= '0;
            pdbg_q    <= '0;
            pconf_q   <= '0;
            pstarve_q <= '0;
        end else if (perf_clr) begin
            pcpu_q    <= '0;
            pdbg_q    <= '0;
            pconf_q   <= '0;
            pstarve_q <= '0;
        end else begin
            if (cpu_gnt && pcpu_q != 16'hFFFF)              pcpu_q    <= pcpu_q + 16'd1;
            if (dbg_gnt && pdbg_q != 16'hFFFF)              pdbg_q    <= pdbg_q + 16'd1;
            if (cpu_req && dbg_req && pconf_q != 16'hFFFF)  pconf_q   <= pconf_q + 16'd1;
            if (guard_win && pstarve_q != 16'hFFFF)         pstarve_q <= pstarve_q + 16'd1;
        end
    end

    assign perf_cpu_cnt      = pcpu_q;
    assign perf_dbg_cnt      = pdbg_q;
    assign perf_conflict_cnt = pconf_q;
    assign perf_starve_cnt   = pstarve_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous memory.
module tb_dmem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          resetn;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
    logic          perf_clr;
    logic [15:0]   perf_cpu_cnt, perf_dbg_cnt, perf_conflict_cnt, perf_starve_cnt;
`endif

    logic [DW-1:0] mem [0:255];
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_clr(perf_clr), .perf_cpu_cnt(perf_cpu_cnt), .perf_dbg_cnt(perf_dbg_cnt),
        .perf_conflict_cnt(perf_conflict_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    // Single-port synchronous memory: read data appears one clock after the address.
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drv_dbg(input logic req, input logic we, input logic lock,
                           input logic [31:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        logic exp_d, prev_c, prev_d;
        logic [31:0] w;

        for (int k = 0; k < 256; k++) mem[k] = '0;
        resetn = 1'b0;
        drv_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        drv_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DMEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        // Reset: requests present but nothing granted, memory pins at zero
        #2;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("rst_perf_cpu", 32'(perf_cpu_cnt), 32'd0);
`endif

        // CPU write then read of 0x10
        @(negedge clock); resetn = 1'b1; #1;
        chk("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("wr_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clock); drv_cpu(1'b1, 1'b0, 32'h10, 32'h0); #1;
        chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_no_rvalid_after_wr", 32'(cpu_rvalid), 32'd0);
        @(negedge clock); drv_cpu(1'b0, 1'b0, 32'h55, 32'h0); #1;
        chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("idle_mem_addr_hold", mem_addr, 32'h10);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        @(negedge clock); #1;
        chk("rd_rvalid_one_cycle", 32'(cpu_rvalid), 32'd0);

`ifdef DMEM_ARB_PERF_EN
        @(negedge clock); perf_clr = 1'b1;
        @(negedge clock); perf_clr = 1'b0;
`endif
        // Starvation guard: both requesting for 10 cycles, debug wins every 5th
        prev_c = 1'b0; prev_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drv_cpu(1'b1, 1'b0, 32'h10, 32'h0);
            drv_dbg(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
            #1;
            exp_d = ((i % 5) == 4);
            chk($sformatf("starve_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(!exp_d));
            chk($sformatf("starve_dbg_gnt[%0d]", i), 32'(dbg_gnt), 32'(exp_d));
            chk($sformatf("starve_cpu_rvalid[%0d]", i), 32'(cpu_rvalid), 32'(prev_c));
            chk($sformatf("starve_dbg_rvalid[%0d]", i), 32'(dbg_rvalid), 32'(prev_d));
            prev_c = !exp_d; prev_d = exp_d;
        end
        @(negedge clock);
        drv_cpu(1'b0, 1'b0, 32'h10, 32'h0);
        drv_dbg(1'b0, 1'b0, 1'b0, 32'h30, 32'h0);
        #1;
        chk("starve_tail_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("starve_tail_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_conflict", 32'(perf_conflict_cnt), 32'd10);
        chk("perf_dbg", 32'(perf_dbg_cnt), 32'd2);
        chk("perf_cpu", 32'(perf_cpu_cnt), 32'd8);
        chk("perf_starve", 32'(perf_starve_cnt), 32'd2);
`endif

        // Locked debug burst to 0x20..0x22 against a continuous CPU request
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            w = (i < 5) ? 32'd0 : 32'(i - 4);
            drv_cpu(1'b1, 1'b0, 32'h10, 32'h0);
            if (i < 7) drv_dbg(1'b1, 1'b1, 1'b1, 32'h20 + w, 32'hA0 + w);
            else       drv_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            exp_d = (i >= 4 && i <= 6);
            chk($sformatf("burst_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(!exp_d));
            chk($sformatf("burst_dbg_gnt[%0d]", i), 32'(dbg_gnt), 32'(exp_d));
            chk($sformatf("burst_mem_we[%0d]", i), 32'(mem_we), 32'(exp_d));
            chk($sformatf("burst_mem_addr[%0d]", i), mem_addr, exp_d ? 32'h20 + w : 32'h10);
        end
        @(negedge clock); drv_cpu(1'b0, 1'b0, 32'h10, 32'h0);

        // Alternating reads across owners
        @(negedge clock); drv_cpu(1'b1, 1'b0, 32'h10, 32'h0); #1;
        chk("alt_cpu_gnt", 32'(cpu_gnt), 32'd1);
        @(negedge clock);
        drv_cpu(1'b0, 1'b0, 32'h10, 32'h0);
        drv_dbg(1'b1, 1'b0, 1'b0, 32'h21, 32'h0);
        #1;
        chk("alt_dbg_gnt", 32'(dbg_gnt), 32'd1);
        chk("alt_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("alt_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("alt_dbg_rvalid_early", 32'(dbg_rvalid), 32'd0);
        @(negedge clock); drv_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        chk("alt_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("alt_dbg_rdata", dbg_rdata, 32'hA1);
        chk("alt_cpu_rvalid_late", 32'(cpu_rvalid), 32'd0);

        // Reset while locked with a debug read pending
        @(negedge clock); drv_dbg(1'b1, 1'b0, 1'b1, 32'h22, 32'h0); #1;
        chk("lockrd_dbg_gnt", 32'(dbg_gnt), 32'd1);
        @(negedge clock); resetn = 1'b0; #1;
        chk("midrst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("midrst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        @(negedge clock); #1;
        chk("midrst_dbg_rvalid2", 32'(dbg_rvalid), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        drv_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("postrst_arb_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("postrst_arb_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("postrst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        @(negedge clock); drv_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        chk("postrst_lone_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("postrst_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("postrst_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("postrst_dbg_rvalid2", 32'(dbg_rvalid), 32'd0);
        @(negedge clock); drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
